// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the multicycle PC sequencer:
// PC mux select codes, decoder op classes and FSM state encodings.
package cpu_ctrl_pkg;

   // PC source mux select codes
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_EPC    = 2'b11;

   // Decoder instruction classes; any other code is illegal
   localparam logic [2:0] OP_SEQ    = 3'b000;
   localparam logic [2:0] OP_BRANCH = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_ERET   = 3'b011;
   localparam logic [2:0] OP_BREAK  = 3'b100;

   // Binary state encodings; codes 10..15 are unused and recover to ST_RESET
   typedef enum logic [3:0] {
      ST_RESET    = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_EXEC     = 4'd3,
      ST_BRANCH   = 4'd4,
      ST_JUMP     = 4'd5,
      ST_ERET     = 4'd6,
      ST_EXC_SAVE = 4'd7,
      ST_EXC_VEC  = 4'd8,
      ST_HALT     = 4'd9
   } state_t;

endpackage

// File: rtl/mem_wait_cnt.sv
// Memory-latency wait counter. While run is high it counts 0..MEM_LAT-1 and
// flags done on the last cycle, then wraps to 0 so the next access starts clean.
// Whenever run is low the count is held at 0.
module mem_wait_cnt #(
   parameter int MEM_LAT = 2,
   localparam int CW = $clog2(MEM_LAT + 1)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   output logic done
);

   localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

   logic [CW-1:0] cnt;

   assign done = run && (cnt == LAST);

   // Count cycles of an access in progress; clear on completion or when idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (!run || done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle PC-update controller. Walks fetch, decode, execute, branch, jump,
// exception entry and ERET, driving the PC source select and the PC/IR/EPC
// load enables plus the memory read strobe. Outputs are pure decodes of the
// registered state and wait count (plus branch_taken while branching).
module pc_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] op_class,
   input  logic       branch_taken,
   input  logic       exec_done,
   input  logic       exc_req,
   output logic [1:0] PCSrc,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemRead,
   output logic       EPCWrite,
   output logic [3:0] state_o
);

   state_t state;
   state_t state_next;
   logic   mem_run;
   logic   mem_done;

   // Both the instruction fetch and the exception-vector load wait on memory
   assign mem_run = (state == ST_FETCH) || (state == ST_EXC_VEC);

   mem_wait_cnt #(
      .MEM_LAT (MEM_LAT)
   ) u_wait (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (mem_run),
      .done    (mem_done)
   );

   assign state_o = state;

   // State register; reset drops straight into ST_RESET from anywhere
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_RESET;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output decode; PC and EPC loads live in disjoint states
   always_comb begin
      state_next = state;
      PCSrc      = PCSRC_ALU;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      EPCWrite   = 1'b0;

      case (state)
         ST_RESET: begin
            state_next = ST_FETCH;
         end

         ST_FETCH: begin
            MemRead = 1'b1;
            if (mem_done) begin
               PCSrc      = PCSRC_ALU;
               PCWrite    = 1'b1;
               IRWrite    = 1'b1;
               state_next = ST_DECODE;
            end
         end

         ST_DECODE: begin
            case (op_class)
               OP_SEQ:    state_next = ST_EXEC;
               OP_BRANCH: state_next = ST_BRANCH;
               OP_JUMP:   state_next = ST_JUMP;
               OP_ERET:   state_next = ST_ERET;
               OP_BREAK:  state_next = ST_HALT;
               default:   state_next = ST_EXC_SAVE;
            endcase
         end

         ST_EXEC: begin
            if (exc_req) begin
               state_next = ST_EXC_SAVE;
            end else if (exec_done) begin
               state_next = ST_FETCH;
            end
         end

         ST_BRANCH: begin
            PCSrc      = PCSRC_ALUOUT;
            PCWrite    = branch_taken;
            state_next = ST_FETCH;
         end

         ST_JUMP: begin
            PCSrc      = PCSRC_JUMP;
            PCWrite    = 1'b1;
            state_next = ST_FETCH;
         end

         ST_ERET: begin
            PCSrc      = PCSRC_EPC;
            PCWrite    = 1'b1;
            state_next = ST_FETCH;
         end

         ST_EXC_SAVE: begin
            EPCWrite   = 1'b1;
            state_next = ST_EXC_VEC;
         end

         ST_EXC_VEC: begin
            MemRead = 1'b1;
            if (mem_done) begin
               PCSrc      = PCSRC_ALUOUT;
               PCWrite    = 1'b1;
               state_next = ST_FETCH;
            end
         end

         ST_HALT: begin
            state_next = ST_HALT;
         end

         default: begin
            state_next = ST_RESET;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// multi-cycle sequences, then random stimulus against a schedule-queue model.
module tb_pc_sequencer;
   import cpu_ctrl_pkg::*;

   localparam int MEM_LAT = 2;
   localparam logic [5:0] IDLE = 6'b000000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] op_class = 3'b000;
   logic       branch_taken = 1'b0;
   logic       exec_done = 1'b0;
   logic       exc_req = 1'b0;
   logic [1:0] PCSrc;
   logic       PCWrite;
   logic       IRWrite;
   logic       MemRead;
   logic       EPCWrite;
   logic [3:0] state_o;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(
      .MEM_LAT (MEM_LAT)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .op_class     (op_class),
      .branch_taken (branch_taken),
      .exec_done    (exec_done),
      .exc_req      (exc_req),
      .PCSrc        (PCSrc),
      .PCWrite      (PCWrite),
      .IRWrite      (IRWrite),
      .MemRead      (MemRead),
      .EPCWrite     (EPCWrite),
      .state_o      (state_o)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Output bundle order: {PCSrc, PCWrite, IRWrite, MemRead, EPCWrite}
   function automatic logic [5:0] mk(input logic [1:0] s, input logic pw, input logic iw,
                                     input logic mr, input logic ew);
      return {s, pw, iw, mr, ew};
   endfunction

   // Drive inputs just after the falling edge, then settle before sampling
   task automatic applyStimulus(input logic [2:0] op, input logic bt, input logic ed,
                                input logic er);
      @(negedge clk);
      op_class     = op;
      branch_taken = bt;
      exec_done    = ed;
      exc_req      = er;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [5:0] exp);
      logic [5:0] got;
      got = {PCSrc, PCWrite, IRWrite, MemRead, EPCWrite};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b (PCSrc,PCWrite,IRWrite,MemRead,EPCWrite)",
                  name, got, exp);
      end
   endtask

   task automatic checkResetState(input string name);
      checks++;
      if (state_o !== ST_RESET) begin
         errors++;
         $display("[TB] FAIL %s: state_o got %0d expected %0d", name, state_o, ST_RESET);
      end
   endtask

   // Hold reset for one cycle, release, and land in the ST_RESET cycle
   task automatic doReset();
      @(negedge clk);
      reset_n = 1'b0;
      op_class = OP_SEQ; branch_taken = 1'b0; exec_done = 1'b0; exc_req = 1'b0;
      #1;
      checkOutput("reset_hold", IDLE);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("reset_release", IDLE);
      checkResetState("reset_state");
   endtask

   // MEM_LAT fetch cycles: MemRead throughout, PC/IR load on the last one
   task automatic runFetch(input string tag);
      for (int i = 0; i < MEM_LAT; i++) begin
         applyStimulus(OP_SEQ, 1'b0, 1'b0, 1'b0);
         if (i == MEM_LAT - 1)
            checkOutput({tag, "_fetch_last"}, mk(PCSRC_ALU, 1'b1, 1'b1, 1'b1, 1'b0));
         else
            checkOutput({tag, "_fetch_wait"}, mk(PCSRC_ALU, 1'b0, 1'b0, 1'b1, 1'b0));
      end
   endtask

   // EPC save, vector load (stray exec_done/exc_req must be ignored), then refetch
   task automatic excPath(input string tag);
      applyStimulus(OP_SEQ, 1'b0, 1'b1, 1'b1);
      checkOutput({tag, "_epc_save"}, mk(PCSRC_ALU, 1'b0, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < MEM_LAT; i++) begin
         applyStimulus(OP_SEQ, 1'b0, 1'b1, 1'b1);
         if (i == MEM_LAT - 1)
            checkOutput({tag, "_vec_last"}, mk(PCSRC_ALUOUT, 1'b1, 1'b0, 1'b1, 1'b0));
         else
            checkOutput({tag, "_vec_wait"}, mk(PCSRC_ALU, 1'b0, 1'b0, 1'b1, 1'b0));
      end
      applyStimulus(OP_SEQ, 1'b0, 1'b0, 1'b0);
      checkOutput({tag, "_refetch"}, mk(PCSRC_ALU, 1'b0, 1'b0, 1'b1, 1'b0));
   endtask

   // ---------------- reference model: queue of scheduled cycles ----------------
   typedef enum {K_FIXED, K_DECODE, K_EXEC, K_BRANCH, K_HALT} kind_e;
   typedef struct {
      kind_e      kind;
      logic [5:0] outs;
   } slot_t;

   slot_t plan[$];

   task automatic pushFetch();
      for (int i = 0; i < MEM_LAT; i++)
         plan.push_back('{K_FIXED, (i == MEM_LAT - 1) ? mk(PCSRC_ALU, 1'b1, 1'b1, 1'b1, 1'b0)
                                                      : mk(PCSRC_ALU, 1'b0, 1'b0, 1'b1, 1'b0)});
      plan.push_back('{K_DECODE, IDLE});
   endtask

   task automatic pushExc();
      plan.push_back('{K_FIXED, mk(PCSRC_ALU, 1'b0, 1'b0, 1'b0, 1'b1)});
      for (int i = 0; i < MEM_LAT; i++)
         plan.push_back('{K_FIXED, (i == MEM_LAT - 1) ? mk(PCSRC_ALUOUT, 1'b1, 1'b0, 1'b1, 1'b0)
                                                      : mk(PCSRC_ALU, 1'b0, 1'b0, 1'b1, 1'b0)});
      pushFetch();
   endtask

   task automatic modelReset();
      plan.delete();
      plan.push_back('{K_FIXED, IDLE});
      pushFetch();
   endtask

   function automatic logic [5:0] modelExpect(input logic bt);
      if (plan[0].kind == K_BRANCH) return mk(PCSRC_ALUOUT, bt, 1'b0, 1'b0, 1'b0);
      return plan[0].outs;
   endfunction

   task automatic modelStep(input logic [2:0] op, input logic ed, input logic er);
      case (plan[0].kind)
         K_HALT: ;
         K_EXEC: begin
            if (er) begin
               void'(plan.pop_front());
               pushExc();
            end else if (ed) begin
               void'(plan.pop_front());
               pushFetch();
            end
         end
         K_DECODE: begin
            void'(plan.pop_front());
            case (op)
               3'd0: plan.push_back('{K_EXEC, IDLE});
               3'd1: begin plan.push_back('{K_BRANCH, IDLE}); pushFetch(); end
               3'd2: begin plan.push_back('{K_FIXED, mk(PCSRC_JUMP, 1'b1, 1'b0, 1'b0, 1'b0)}); pushFetch(); end
               3'd3: begin plan.push_back('{K_FIXED, mk(PCSRC_EPC, 1'b1, 1'b0, 1'b0, 1'b0)}); pushFetch(); end
               3'd4: plan.push_back('{K_HALT, IDLE});
               default: pushExc();
            endcase
         end
         default: void'(plan.pop_front());
      endcase
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [2:0] op;
      logic       bt;
      logic [1:0] pcsrc;
      logic       pcw;
      logic       refetch;
   } vec_t;

   // Watchdog: the bench never waits on DUT events, but guard anyway
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vec_t vecs[6];
      int   halted;
      bit   forceReset;
      logic [2:0] rop;

      vecs[0] = '{OP_BRANCH, 1'b1, PCSRC_ALUOUT, 1'b1, 1'b1};
      vecs[1] = '{OP_BRANCH, 1'b0, PCSRC_ALUOUT, 1'b0, 1'b1};
      vecs[2] = '{OP_JUMP,   1'b0, PCSRC_JUMP,   1'b1, 1'b1};
      vecs[3] = '{OP_ERET,   1'b1, PCSRC_EPC,    1'b1, 1'b1};
      vecs[4] = '{OP_SEQ,    1'b1, PCSRC_ALU,    1'b0, 1'b0};
      vecs[5] = '{OP_BREAK,  1'b1, PCSRC_ALU,    1'b0, 1'b0};

      // Single-cycle post-decode behaviour for each op class
      for (int i = 0; i < 6; i++) begin
         doReset();
         runFetch($sformatf("vec%0d", i));
         applyStimulus(vecs[i].op, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("vec%0d_decode", i), IDLE);
         applyStimulus(OP_SEQ, vecs[i].bt, 1'b0, 1'b0);
         checkOutput($sformatf("vec%0d_action", i),
                     mk(vecs[i].pcsrc, vecs[i].pcw, 1'b0, 1'b0, 1'b0));
         applyStimulus(OP_SEQ, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("vec%0d_after", i),
                     mk(PCSRC_ALU, 1'b0, 1'b0, vecs[i].refetch, 1'b0));
      end

      // SEQ: fetch load on cycle 3 after release, exc_req in decode ignored,
      // exec waits for exec_done then refetches
      doReset();
      runFetch("seq");
      applyStimulus(OP_SEQ, 1'b0, 1'b0, 1'b1);
      checkOutput("seq_decode", IDLE);
      applyStimulus(OP_SEQ, 1'b0, 1'b0, 1'b0);
      checkOutput("seq_exec_wait", IDLE);
      applyStimulus(OP_SEQ, 1'b0, 1'b0, 1'b0);
      checkOutput("seq_exec_wait2", IDLE);
      applyStimulus(OP_SEQ, 1'b0, 1'b1, 1'b0);
      checkOutput("seq_exec_done", IDLE);
      applyStimulus(OP_SEQ, 1'b0, 1'b0, 1'b0);
      checkOutput("seq_refetch", mk(PCSRC_ALU, 1'b0, 1'b0, 1'b1, 1'b0));

      // exc_req and exec_done together in exec: exception wins
      doReset();
      runFetch("exc");
      applyStimulus(OP_SEQ, 1'b0, 1'b0, 1'b0);
      checkOutput("exc_decode", IDLE);
      applyStimulus(OP_SEQ, 1'b0, 1'b1, 1'b1);
      checkOutput("exc_exec", IDLE);
      excPath("exc");

      // Illegal op class takes the exception path straight from decode
      doReset();
      runFetch("ill");
      applyStimulus(3'b111, 1'b0, 1'b0, 1'b0);
      checkOutput("ill_decode", IDLE);
      excPath("ill");

      // BREAK halts: nothing moves for 20 cycles whatever the inputs do
      doReset();
      runFetch("brk");
      applyStimulus(OP_BREAK, 1'b0, 1'b0, 1'b0);
      checkOutput("brk_decode", IDLE);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(3'($urandom_range(0, 7)), 1'b1, 1'b1, 1'b1);
         checkOutput($sformatf("halt%0d", i), IDLE);
      end

      // Asynchronous reset in the middle of a fetch, then a clean restart
      doReset();
      applyStimulus(OP_SEQ, 1'b0, 1'b0, 1'b0);
      checkOutput("midfetch_before", mk(PCSRC_ALU, 1'b0, 1'b0, 1'b1, 1'b0));
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midfetch_async", IDLE);
      checkResetState("midfetch_state");
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("midfetch_restart", IDLE);
      runFetch("midfetch");

      // Random stimulus against the schedule-queue model
      halted = 0;
      forceReset = 1'b1;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         rop = 3'($urandom_range(0, 7));
         if (rop == OP_BREAK && $urandom_range(0, 3) != 0) rop = OP_SEQ;
         op_class     = rop;
         branch_taken = 1'($urandom_range(0, 1));
         exec_done    = ($urandom_range(0, 2) == 0);
         exc_req      = ($urandom_range(0, 7) == 0);
         if (forceReset || $urandom_range(0, 59) == 0) begin
            reset_n = 1'b0;
            #1;
            checkOutput($sformatf("rand_reset%0d", n), IDLE);
            modelReset();
            halted = 0;
            forceReset = 1'b0;
         end else begin
            reset_n = 1'b1;
            #1;
            checkOutput($sformatf("rand_cycle%0d", n), modelExpect(branch_taken));
            if (plan[0].kind == K_HALT) halted++;
            if (halted > 6) forceReset = 1'b1;
            modelStep(op_class, exec_done, exc_req);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
